glip_throughput_meter: RTL and testbench

- Multi-channel byte-rate meter for GLIP FIFO interfaces.
- Passively snoops valid/ready handshakes on up to CHANNELS streams.
- Accumulates transferred bytes per fixed window in packed BCD, then publishes per-channel samples for LCD/LED display logic.
- Sits beside glip_cypressfx3_toplevel in demo and board tops, replacing ad-hoc per-demo counters; adds configurable width, channels, window, saturation and peak-hold.

---
 rtl/glip_throughput_meter_pkg.sv | 22 ++
 rtl/glip_throughput_meter_if.sv | 15 +
 rtl/glip_throughput_meter_accum.sv | 86 ++++++++
 rtl/glip_throughput_meter.sv | 128 ++++++++++++
 tb/tb_glip_throughput_meter.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/glip_throughput_meter_pkg.sv
// glip_throughput_meter_pkg -- shared constants, types and slice helper for the throughput meter.
// Rev 1.0
`default_nettype none

package glip_throughput_meter_pkg;

   localparam int BCD_W              = 4;
   localparam int MAX_BYTES_PER_BEAT = 9;
   localparam int MIN_DIGITS         = 2;
   localparam int MAX_DIGITS         = 10;
   localparam int MAX_CHANNELS       = 8;

   typedef logic [BCD_W-1:0] bcd_digit_t;

   // LSB of channel 'chan' inside a flat vector of DIGITS-digit BCD words.
   function automatic int chan_lsb(input int chan, input int digits);
      return chan * digits * BCD_W;
   endfunction

endpackage

`default_nettype wire

// File: rtl/glip_throughput_meter_if.sv
// glip_throughput_meter_if -- bundle of the snooped per-channel valid/ready handshakes.
// Rev 1.0
`default_nettype none

interface glip_throughput_meter_if #(
   parameter int CHANNELS = 2
);
   logic [CHANNELS-1:0] chan_valid;
   logic [CHANNELS-1:0] chan_ready;

   modport master (output chan_valid, output chan_ready);
   modport slave  (input  chan_valid, input  chan_ready);
endinterface

`default_nettype wire

// File: rtl/glip_throughput_meter_accum.sv
// glip_bcd_accum -- DIGITS-digit saturating packed-BCD byte accumulator with sticky overflow.
// Rev 1.0
`default_nettype none

module glip_bcd_accum
   import glip_throughput_meter_pkg::*;
#(
   parameter int DIGITS         = 9,
   parameter int BYTES_PER_BEAT = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    add_i,
   input  logic                    load_start_i,
   input  logic                    clear_i,
   output logic [DIGITS*BCD_W-1:0] value_o,
   output logic                    ovf_o
);

   localparam bcd_digit_t BPB_DIGIT = bcd_digit_t'(BYTES_PER_BEAT);

   bcd_digit_t [DIGITS-1:0] acc_q, acc_d, inc;
   logic                    ovf_q, ovf_d;
   logic                    carry;
   logic                    carry_out;
   logic [BCD_W:0]          dsum;

   // Ripple the per-beat addend through all digits in a single cycle.
   always_comb begin
      inc   = '0;
      dsum  = '0;
      carry = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         dsum = {1'b0, acc_q[i]} + {{BCD_W{1'b0}}, carry};
         if (i == 0) begin
            dsum = dsum + {1'b0, BPB_DIGIT};
         end
         if (dsum >= 5'd10) begin
            inc[i] = bcd_digit_t'(dsum - 5'd10);
            carry  = 1'b1;
         end else begin
            inc[i] = dsum[BCD_W-1:0];
            carry  = 1'b0;
         end
      end
      carry_out = carry;
   end

   always_comb begin
      acc_d = acc_q;
      ovf_d = ovf_q;
      if (clear_i) begin
         acc_d = '0;
         ovf_d = 1'b0;
      end else if (load_start_i) begin
         acc_d = '0;
         if (add_i) begin
            acc_d[0] = BPB_DIGIT;
         end
         ovf_d = 1'b0;
      end else if (add_i && !ovf_q) begin
         if (carry_out) begin
            acc_d = {DIGITS{4'h9}};
            ovf_d = 1'b1;
         end else begin
            acc_d = inc;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         ovf_q <= ovf_d;
      end
   end

   assign value_o = acc_q;
   assign ovf_o   = ovf_q;

endmodule

`default_nettype wire

// File: rtl/glip_throughput_meter.sv
// glip_throughput_meter -- per-window BCD byte-rate meter over snooped GLIP FIFO handshakes.
// Rev 1.0
`default_nettype none

module glip_throughput_meter
   import glip_throughput_meter_pkg::*;
#(
   parameter int          CHANNELS       = 2,
   parameter int          BYTES_PER_BEAT = 2,
   parameter logic [31:0] WINDOW         = 32'd10000000,
   parameter int          DIGITS         = 9
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             enable,
   glip_throughput_meter_if.slave           snoop,
   input  logic                             peak_mode,
   input  logic                             peak_clr,
   output logic [CHANNELS*DIGITS*BCD_W-1:0] sample_bcd,
   output logic [CHANNELS-1:0]              sample_ovf,
   output logic                             sample_strobe,
   output logic [CHANNELS-1:0]              activity,
   output logic [31:0]                      window_phase
);

   localparam int          DW       = DIGITS * BCD_W;
   localparam logic [31:0] WIN_LAST = WINDOW - 32'd1;

   if (BYTES_PER_BEAT < 1 || BYTES_PER_BEAT > MAX_BYTES_PER_BEAT) begin : g_bad_bpb
      $error("glip_throughput_meter: BYTES_PER_BEAT=%0d outside 1..%0d", BYTES_PER_BEAT, MAX_BYTES_PER_BEAT);
   end
   if (DIGITS < MIN_DIGITS || DIGITS > MAX_DIGITS) begin : g_bad_digits
      $error("glip_throughput_meter: DIGITS=%0d outside %0d..%0d", DIGITS, MIN_DIGITS, MAX_DIGITS);
   end
   if (CHANNELS < 1 || CHANNELS > MAX_CHANNELS) begin : g_bad_channels
      $error("glip_throughput_meter: CHANNELS=%0d outside 1..%0d", CHANNELS, MAX_CHANNELS);
   end
   if (WINDOW < 32'd2) begin : g_bad_window
      $error("glip_throughput_meter: WINDOW must be at least 2");
   end

   logic [CHANNELS-1:0]    beat;
   logic                   terminal;
   logic [CHANNELS*DW-1:0] acc_flat;
   logic [CHANNELS-1:0]    acc_ovf;

   logic [31:0]            win_q, win_d;
   logic [CHANNELS*DW-1:0] samp_q, samp_d;
   logic [CHANNELS-1:0]    sovf_q, sovf_d;
   logic                   strobe_q;
   logic [CHANNELS-1:0]    act_q;
   logic [DW-1:0]          cand;

   assign beat     = snoop.chan_valid & snoop.chan_ready;
   assign terminal = enable && (win_q == WIN_LAST);

   always_comb begin
      win_d = win_q + 32'd1;
      if (!enable || terminal) begin
         win_d = '0;
      end
   end

   // Terminal-cycle beats are excluded from the candidate: load_start seeds the next window with them.
   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      glip_bcd_accum #(
         .DIGITS         (DIGITS),
         .BYTES_PER_BEAT (BYTES_PER_BEAT)
      ) u_accum (
         .clk          (clk),
         .rst_n        (rst_n),
         .add_i        (beat[c]),
         .load_start_i (terminal),
         .clear_i      (!enable),
         .value_o      (acc_flat[chan_lsb(c, DIGITS) +: DW]),
         .ovf_o        (acc_ovf[c])
      );
   end

   // Packed BCD compares correctly as plain unsigned, so peak-hold needs no decimal decode.
   always_comb begin
      samp_d = samp_q;
      sovf_d = sovf_q;
      cand   = '0;
      if (peak_clr) begin
         samp_d = '0;
         sovf_d = '0;
      end else if (terminal) begin
         for (int c = 0; c < CHANNELS; c++) begin
            cand = acc_flat[chan_lsb(c, DIGITS) +: DW];
            if (!peak_mode) begin
               samp_d[chan_lsb(c, DIGITS) +: DW] = cand;
               sovf_d[c]                         = acc_ovf[c];
            end else begin
               if (cand > samp_q[chan_lsb(c, DIGITS) +: DW]) begin
                  samp_d[chan_lsb(c, DIGITS) +: DW] = cand;
               end
               sovf_d[c] = sovf_q[c] | acc_ovf[c];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_q    <= '0;
         samp_q   <= '0;
         sovf_q   <= '0;
         strobe_q <= 1'b0;
         act_q    <= '0;
      end else begin
         win_q    <= win_d;
         samp_q   <= samp_d;
         sovf_q   <= sovf_d;
         strobe_q <= terminal;
         act_q    <= beat;
      end
   end

   assign sample_bcd    = samp_q;
   assign sample_ovf    = sovf_q;
   assign sample_strobe = strobe_q;
   assign activity      = act_q;
   assign window_phase  = win_q;

endmodule

`default_nettype wire

// File: tb/tb_glip_throughput_meter.sv
// tb_glip_throughput_meter -- self-checking bench: window table, corner sequences, randomized model check.
// Rev 1.0
`default_nettype none

module tb_glip_throughput_meter;

   localparam int          CH    = 2;
   localparam int          BPB   = 2;
   localparam int          DG    = 4;
   localparam logic [31:0] WIN   = 32'd16;
   localparam longint      MAXV  = 9999;
   localparam int          WIN_B = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // DUT A: main meter (2 channels, 4 digits, 16-cycle window)
   logic          en_a = 1'b0, pm_a = 1'b0, pc_a = 1'b0;
   logic [CH-1:0] v_a = '0, r_a = '0;
   logic [CH*DG*4-1:0] samp_a;
   logic [CH-1:0] sovf_a, act_a;
   logic          strobe_a;
   logic [31:0]   phase_a;

   glip_throughput_meter_if #(.CHANNELS(CH)) bus_a ();
   assign bus_a.chan_valid = v_a;
   assign bus_a.chan_ready = r_a;

   glip_throughput_meter #(
      .CHANNELS(CH), .BYTES_PER_BEAT(BPB), .WINDOW(WIN), .DIGITS(DG)
   ) u_dut_a (
      .clk(clk), .rst_n(rst_n), .enable(en_a), .snoop(bus_a.slave),
      .peak_mode(pm_a), .peak_clr(pc_a), .sample_bcd(samp_a), .sample_ovf(sovf_a),
      .sample_strobe(strobe_a), .activity(act_a), .window_phase(phase_a)
   );

   // DUT B: saturation meter (1 channel, 2 digits, 64-cycle window)
   logic        en_b = 1'b0, v_b = 1'b0;
   logic [7:0]  samp_b;
   logic [0:0]  sovf_b, act_b;
   logic        strobe_b;
   logic [31:0] phase_b;

   glip_throughput_meter_if #(.CHANNELS(1)) bus_b ();
   assign bus_b.chan_valid = v_b;
   assign bus_b.chan_ready = 1'b1;

   glip_throughput_meter #(
      .CHANNELS(1), .BYTES_PER_BEAT(2), .WINDOW(32'd64), .DIGITS(2)
   ) u_dut_b (
      .clk(clk), .rst_n(rst_n), .enable(en_b), .snoop(bus_b.slave),
      .peak_mode(1'b0), .peak_clr(1'b0), .sample_bcd(samp_b), .sample_ovf(sovf_b),
      .sample_strobe(strobe_b), .activity(act_b), .window_phase(phase_b)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Reference model: byte counts as integers, decimal saturation, BCD only at compare time.
   longint      m_acc  [CH];
   bit          m_aovf [CH];
   longint      m_samp [CH];
   bit          m_sovf [CH];
   bit          m_strobe;
   bit [CH-1:0] m_act;
   longint      m_cnt;

   function automatic logic [DG*4-1:0] to_bcd(input longint v);
      logic [DG*4-1:0] r;
      longint          t;
      r = '0;
      t = v;
      for (int i = 0; i < DG; i++) begin
         r[i*4 +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         m_acc[c] = 0; m_aovf[c] = 0; m_samp[c] = 0; m_sovf[c] = 0;
      end
      m_strobe = 0; m_act = '0; m_cnt = 0;
   endtask

   task automatic model_step();
      bit [CH-1:0] bt;
      bit          term;
      bt       = v_a & r_a;
      term     = en_a && (m_cnt == longint'(WIN) - 1);
      m_strobe = term;
      m_act    = bt;
      for (int c = 0; c < CH; c++) begin
         if (pc_a) begin
            m_samp[c] = 0; m_sovf[c] = 0;
         end else if (term) begin
            if (!pm_a) begin
               m_samp[c] = m_acc[c]; m_sovf[c] = m_aovf[c];
            end else begin
               if (m_acc[c] > m_samp[c]) m_samp[c] = m_acc[c];
               m_sovf[c] = m_sovf[c] | m_aovf[c];
            end
         end
         if (!en_a) begin
            m_acc[c] = 0; m_aovf[c] = 0;
         end else if (term) begin
            m_acc[c] = bt[c] ? BPB : 0; m_aovf[c] = 0;
         end else if (bt[c]) begin
            m_acc[c] = m_acc[c] + BPB;
            if (m_acc[c] > MAXV) begin
               m_acc[c] = MAXV; m_aovf[c] = 1;
            end
         end
      end
      m_cnt = (!en_a || term) ? 0 : m_cnt + 1;
   endtask

   // One clock: DUT edge, model step, full output comparison of DUT A.
   task automatic cycle();
      @(posedge clk);
      #1;
      model_step();
      check("sample_bcd", samp_a, {to_bcd(m_samp[1]), to_bcd(m_samp[0])});
      check("sample_ovf", sovf_a, {m_sovf[1], m_sovf[0]});
      check("sample_strobe", strobe_a, m_strobe);
      check("activity", act_a, m_act);
      check("window_phase", phase_a, m_cnt);
   endtask

   // Beat when b; otherwise a random non-beat valid/ready combination.
   task automatic drive_chan(input int c, input bit b);
      int p;
      if (b) begin
         v_a[c] = 1'b1; r_a[c] = 1'b1;
      end else begin
         p = $urandom_range(0, 2);
         v_a[c] = (p == 1); r_a[c] = (p == 2);
      end
   endtask

   typedef struct {
      int          n0;
      int          n1;
      bit          full1;
      bit          pm;
      bit          clr;
      logic [15:0] e0;
      logic [15:0] e1;
   } vec_t;

   vec_t tbl[10];
   int   strobes_seen;

   initial begin
      // ch0 beats at phases 3..3+n0-1; ch1 at 1..n1, or every phase when full1
      tbl[0] = '{5,  0,  1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000};
      tbl[1] = '{8,  3,  1'b0, 1'b0, 1'b0, 16'h0016, 16'h0006};
      tbl[2] = '{8,  0,  1'b0, 1'b1, 1'b0, 16'h0016, 16'h0006};
      tbl[3] = '{12, 7,  1'b0, 1'b1, 1'b0, 16'h0024, 16'h0014};
      tbl[4] = '{4,  14, 1'b0, 1'b1, 1'b0, 16'h0024, 16'h0028};
      tbl[5] = '{6,  2,  1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000};
      tbl[6] = '{2,  1,  1'b0, 1'b1, 1'b0, 16'h0004, 16'h0002};
      tbl[7] = '{0,  0,  1'b1, 1'b0, 1'b0, 16'h0000, 16'h0030};
      tbl[8] = '{0,  0,  1'b1, 1'b0, 1'b0, 16'h0000, 16'h0032};
      tbl[9] = '{3,  4,  1'b0, 1'b0, 1'b0, 16'h0006, 16'h0010};

      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset_sample", samp_a, '0);
      check("reset_ovf", sovf_a, '0);
      check("reset_strobe", strobe_a, 1'b0);
      check("reset_phase", phase_a, '0);
      rst_n = 1'b1;
      en_a  = 1'b1;

      for (int r = 0; r < 10; r++) begin
         pm_a = tbl[r].pm;
         for (int k = 0; k < 16; k++) begin
            drive_chan(0, (k >= 3) && (k < 3 + tbl[r].n0));
            drive_chan(1, tbl[r].full1 || ((k >= 1) && (k <= tbl[r].n1)));
            pc_a = tbl[r].clr && (k == 15);
            cycle();
         end
         pc_a = 1'b0;
         check("tbl_strobe", strobe_a, 1'b1);
         check("tbl_ch0", samp_a[15:0], tbl[r].e0);
         check("tbl_ch1", samp_a[31:16], tbl[r].e1);
         check("tbl_ovf", sovf_a, 2'b00);
      end

      // Reset mid-window after 7 beats: immediate clear, fresh window from release
      pm_a = 1'b0;
      for (int k = 0; k < 7; k++) begin
         drive_chan(0, 1'b1); drive_chan(1, 1'b0);
         cycle();
      end
      rst_n = 1'b0;
      #1;
      check("midrst_sample", samp_a, '0);
      check("midrst_activity", act_a, '0);
      check("midrst_phase", phase_a, '0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 16; k++) begin
         drive_chan(0, k < 3); drive_chan(1, 1'b0);
         cycle();
      end
      check("postrst_strobe", strobe_a, 1'b1);
      check("postrst_ch0", samp_a[15:0], 16'h0006);

      // Enable gap of 20 cycles mid-window with beats present
      for (int k = 0; k < 5; k++) begin
         drive_chan(0, 1'b1); drive_chan(1, 1'b1);
         cycle();
      end
      en_a = 1'b0;
      strobes_seen = 0;
      for (int k = 0; k < 20; k++) begin
         drive_chan(0, 1'b1); drive_chan(1, $urandom_range(0, 1) == 1);
         cycle();
         if (strobe_a) strobes_seen++;
      end
      check("gap_no_strobe", strobes_seen, 0);
      en_a = 1'b1;
      for (int k = 0; k < 16; k++) begin
         drive_chan(0, 1'b0); drive_chan(1, k < 2);
         cycle();
      end
      check("regap_strobe", strobe_a, 1'b1);
      check("regap_ch0", samp_a[15:0], 16'h0000);
      check("regap_ch1", samp_a[31:16], 16'h0004);

      // Saturation on the 2-digit meter
      en_a = 1'b0; v_a = '0; r_a = '0;
      en_b = 1'b1;
      for (int k = 0; k < WIN_B; k++) begin
         v_b = (k < WIN_B - 1);
         cycle();
         if (k == WIN_B - 2) check("sat_no_early_strobe", strobe_b, 1'b0);
      end
      check("sat_strobe", strobe_b, 1'b1);
      check("sat_sample", samp_b, 8'h99);
      check("sat_ovf", sovf_b, 1'b1);
      check("sat_phase_wrap", phase_b, '0);
      for (int k = 0; k < WIN_B; k++) begin
         v_b = (k < 3);
         cycle();
      end
      check("post_sat_strobe", strobe_b, 1'b1);
      check("post_sat_sample", samp_b, 8'h06);
      check("post_sat_ovf", sovf_b, 1'b0);
      en_b = 1'b0; v_b = 1'b0;

      // Randomized traffic against the model
      for (int k = 0; k < 400; k++) begin
         en_a = ($urandom_range(0, 19) != 0);
         v_a  = CH'($urandom);
         r_a  = CH'($urandom);
         if ((k % 16) == 0) pm_a = $urandom_range(0, 1) == 1;
         pc_a = ($urandom_range(0, 29) == 0);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
